// File: rtl/r5_input_collector_if.sv
// ----------------------------------------------------------------------------
// r5_input_collector_if
//   Bundles the sample-in and set-out handshakes of the radix-5 input
//   collector.
//
//   master : the environment side. It drives the input samples and out_ready,
//            and observes the set outputs.
//   slave  : the collector side. It accepts samples and presents sets.
//
//   Signals
//     in_valid/in_ready  sample handshake; in_sof marks the first sample of a group
//     in_re/in_img       complex sample, DW bits per part (IEEE-754 single)
//     out_valid/out_ready set handshake
//     xN_re/xN_img       set entries 0..4 (x0 = first sample of the group)
//     align_err          sticky group-restart indicator
// ----------------------------------------------------------------------------
interface r5_input_collector_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_img;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] x0_re;
    logic [DW-1:0] x1_re;
    logic [DW-1:0] x2_re;
    logic [DW-1:0] x3_re;
    logic [DW-1:0] x4_re;
    logic [DW-1:0] x0_img;
    logic [DW-1:0] x1_img;
    logic [DW-1:0] x2_img;
    logic [DW-1:0] x3_img;
    logic [DW-1:0] x4_img;

    logic          align_err;

    modport master (
        output in_valid, in_sof, in_re, in_img, out_ready,
        input  in_ready, out_valid,
        input  x0_re, x1_re, x2_re, x3_re, x4_re,
        input  x0_img, x1_img, x2_img, x3_img, x4_img,
        input  align_err
    );

    modport slave (
        input  in_valid, in_sof, in_re, in_img, out_ready,
        output in_ready, out_valid,
        output x0_re, x1_re, x2_re, x3_re, x4_re,
        output x0_img, x1_img, x2_img, x3_img, x4_img,
        output align_err
    );
endinterface

// File: rtl/r5_input_collector.sv
// ----------------------------------------------------------------------------
// r5_input_collector
//   Serial-to-parallel front end for the radix-5 FFT butterfly. The block
//   accepts one complex sample per handshake and groups five consecutive
//   samples into one operand set x0..x4. It uses two ping-pong banks, so the
//   input keeps streaming while downstream holds a completed set.
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   r5_input_collector_if.slave (sample in, set out, align_err)
//
//   Data is passed bit-exact. No floating-point interpretation is done.
// ----------------------------------------------------------------------------
module r5_input_collector #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    r5_input_collector_if.slave  bus
);
    localparam int NSAMP = 5;

    typedef logic [DW-1:0] word_t;

    // Two banks of five complex entries.
    word_t      re_q  [2][NSAMP];
    word_t      img_q [2][NSAMP];

    logic [1:0] full_q,      full_d;
    logic       wr_bank_q,   wr_bank_d;
    logic       rd_bank_q,   rd_bank_d;
    logic [2:0] wr_idx_q,    wr_idx_d;
    logic       align_err_q, align_err_d;

    logic       in_rdy;
    logic       accept;
    logic       drain;
    logic [2:0] idx;

    // Ready depends only on registers, plus rst so nothing is taken while
    // the block is being cleared.
    assign in_rdy = !rst && !full_q[wr_bank_q];
    assign accept = bus.in_valid && in_rdy;
    assign drain  = full_q[rd_bank_q] && bus.out_ready;

    // An accepted start-of-group always writes entry 0. This discards any
    // partial group in the current bank.
    assign idx = bus.in_sof ? 3'd0 : wr_idx_q;

    // ------------------------------------------------------------------
    // Control next-state
    // ------------------------------------------------------------------
    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        align_err_d = align_err_q;

        // Drain first. A completing write always targets the other bank,
        // because a full bank blocks writes, so both updates can coexist.
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (accept) begin
            if (bus.in_sof && (wr_idx_q != 3'd0))
                align_err_d = 1'b1;

            if (idx == 3'(NSAMP - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = 3'd0;
            end else begin
                wr_idx_d = idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            align_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            align_err_q <= align_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Sample storage. Storage is cleared on reset so the set outputs read
    // zero afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NSAMP; e++) begin
                    re_q[b][e]  <= '0;
                    img_q[b][e] <= '0;
                end
            end
        end else if (accept) begin
            re_q[wr_bank_q][idx]  <= bus.in_re;
            img_q[wr_bank_q][idx] <= bus.in_img;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. They come straight from the read bank. A pending bank cannot
    // be written, so the set holds while out_ready is low.
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = full_q[rd_bank_q];
    assign bus.align_err = align_err_q;

    assign bus.x0_re  = re_q[rd_bank_q][0];
    assign bus.x1_re  = re_q[rd_bank_q][1];
    assign bus.x2_re  = re_q[rd_bank_q][2];
    assign bus.x3_re  = re_q[rd_bank_q][3];
    assign bus.x4_re  = re_q[rd_bank_q][4];
    assign bus.x0_img = img_q[rd_bank_q][0];
    assign bus.x1_img = img_q[rd_bank_q][1];
    assign bus.x2_img = img_q[rd_bank_q][2];
    assign bus.x3_img = img_q[rd_bank_q][3];
    assign bus.x4_img = img_q[rd_bank_q][4];

endmodule
